// File: rtl/aes_wb_pkg.sv
// Shared constants for the AES Wishbone register front-end: word offsets, bit indices, FSM states.
// Purely declarative; no latency or backpressure of its own.
package aes_wb_pkg;

    localparam int BLK_W = 128;

    // Word offsets (byte address bits [7:2])
    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;

    // 4-word register groups, selected by word offset bits [5:2]
    localparam logic [3:0] GRP_CTRL = 4'h0;
    localparam logic [3:0] GRP_KEY  = 4'h1;
    localparam logic [3:0] GRP_DIN  = 4'h2;
    localparam logic [3:0] GRP_DOUT = 4'h3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic logic [31:0] sel_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_wb_ack_gen.sv
// Wishbone address decode and registered single-cycle acknowledge.
// Ack one cycle after a hit; a held request is acked every second cycle because a live ack blocks the next hit.
module aes_wb_ack_gen #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic [31:0] adr,
    output logic        hit,
    output logic        ack
);

    assign hit = cyc & stb & ((adr & ADDR_MASK) == BASE_ADDR) & ~ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
        end else begin
            ack <= hit;
        end
    end

endmodule

// File: rtl/aes_wb_regs.sv
// Wishbone register window for the AES core: key/plaintext/result registers, start/done sequencing, status and irq.
// Register access completes one cycle after the hit; the core handshake never stalls the bus.
module aes_wb_regs
    import aes_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFFFF_FF00,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [BLK_W-1:0]  core_key_o,
    output logic [BLK_W-1:0]  core_din_o,
    output logic              core_start_o,
    input  logic              core_done_i,
    input  logic [BLK_W-1:0]  core_dout_i,
    output logic              irq_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

    logic          hit;
    logic [5:0]    off;
    logic          wr;
    logic          rd;
    logic          busy;
    logic          start_wr;
    logic          w1c;
    logic          done_set;
    logic          to_set;
    logic [31:0]   rdata;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          irq_en;
    logic          done_q;
    logic          to_q;
    logic [31:0]   key_q  [4];
    logic [31:0]   din_q  [4];
    logic [31:0]   dout_q [4];

    aes_wb_ack_gen #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_ack_gen (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .cyc (wbs_cyc_i),
        .stb (wbs_stb_i),
        .adr (wbs_adr_i),
        .hit (hit),
        .ack (wbs_ack_o)
    );

    assign off      = wbs_adr_i[7:2];
    assign wr       = hit & wbs_we_i;
    assign rd       = hit & ~wbs_we_i;
    assign busy     = (state != IDLE);
    assign start_wr = wr & (off == OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_START];
    assign w1c      = wr & (off == OFF_STATUS) & wbs_sel_i[0];

    // Done takes priority over a timeout landing in the same cycle.
    assign done_set = (state == WAIT) & core_done_i;
    assign to_set   = (state == WAIT) & ~core_done_i & (cnt == CNT_LAST);

    assign core_key_o = {key_q[3], key_q[2], key_q[1], key_q[0]};
    assign core_din_o = {din_q[3], din_q[2], din_q[1], din_q[0]};

    always_comb begin
        rdata = '0;
        case (off[5:2])
            GRP_CTRL: begin
                if (off == OFF_CTRL) begin
                    rdata[CTRL_IRQ_EN] = irq_en;
                end else if (off == OFF_STATUS) begin
                    rdata[ST_BUSY]    = busy;
                    rdata[ST_DONE]    = done_q;
                    rdata[ST_TIMEOUT] = to_q;
                end
            end
            GRP_KEY:  rdata = key_q[off[1:0]];
            GRP_DIN:  rdata = din_q[off[1:0]];
            GRP_DOUT: rdata = dout_q[off[1:0]];
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_dat_o <= '0;
        end else begin
            wbs_dat_o <= rd ? rdata : 32'h0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            core_start_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    core_start_o <= 1'b0;
                    if (start_wr) begin
                        state        <= START;
                        core_start_o <= 1'b1;
                    end
                end
                START: begin
                    core_start_o <= 1'b0;
                    cnt          <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    core_start_o <= 1'b0;
                    if (done_set || to_set) begin
                        state <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    core_start_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en <= 1'b0;
            done_q <= 1'b0;
            to_q   <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (wr && off == OFF_CTRL && wbs_sel_i[0]) begin
                irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            done_q <= done_set | (done_q & ~(w1c & wbs_dat_i[ST_DONE]));
            to_q   <= to_set   | (to_q   & ~(w1c & wbs_dat_i[ST_TIMEOUT]));
            irq_o  <= irq_en & (done_q | to_q);
        end
    end

    // KEY/DIN are frozen while the core may be consuming them.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 4; i++) begin
                key_q[i]  <= '0;
                din_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            if (wr && !busy && off[5:2] == GRP_KEY) begin
                key_q[off[1:0]] <= sel_merge(key_q[off[1:0]], wbs_dat_i, wbs_sel_i);
            end
            if (wr && !busy && off[5:2] == GRP_DIN) begin
                din_q[off[1:0]] <= sel_merge(din_q[off[1:0]], wbs_dat_i, wbs_sel_i);
            end
            if (done_set) begin
                for (int i = 0; i < 4; i++) begin
                    dout_q[i] <= core_dout_i[32*i +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_wb_regs.sv
// Directed plus randomized bench for aes_wb_regs against a word-level register model.
module tb_aes_wb_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cyc = 1'b0;
    logic         stb = 1'b0;
    logic         we  = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  adr = 32'h0;
    logic [31:0]  wdat = 32'h0;
    logic         ack;
    logic [31:0]  rdat_o;
    logic [127:0] key_o;
    logic [127:0] din_o;
    logic         start_o;
    logic         done_i = 1'b0;
    logic [127:0] dout_i = '0;
    logic         irq;

    aes_wb_regs dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat_o),
        .core_key_o   (key_o),
        .core_din_o   (din_o),
        .core_start_o (start_o),
        .core_done_i  (done_i),
        .core_dout_i  (dout_i),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: registers as plain words and flags.
    logic [31:0] m_key [4];
    logic [31:0] m_din [4];
    logic [31:0] m_dout [4];
    bit m_irq_en, m_done, m_to, m_busy;

    logic [31:0]  got;
    bit           acked;
    logic [127:0] blk;
    logic [3:0]   pat;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_key[i] = 0; m_din[i] = 0; m_dout[i] = 0;
        end
        m_irq_en = 0; m_done = 0; m_to = 0; m_busy = 0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input int w);
        if (w == 0)               return {30'h0, m_irq_en, 1'b0};
        if (w == 1)               return {29'h0, m_to, m_done, m_busy};
        if (w >= 4 && w <= 7)     return m_key[w-4];
        if (w >= 8 && w <= 11)    return m_din[w-8];
        if (w >= 12 && w <= 15)   return m_dout[w-12];
        return 32'h0;
    endfunction

    task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
        if (w == 0 && s[0]) begin
            m_irq_en = d[1];
            if (d[0] && !m_busy) m_busy = 1;
        end else if (w == 1 && s[0]) begin
            if (d[1]) m_done = 0;
            if (d[2]) m_to = 0;
        end else if (w >= 4 && w <= 7 && !m_busy) begin
            m_key[w-4] = merge(m_key[w-4], d, s);
        end else if (w >= 8 && w <= 11 && !m_busy) begin
            m_din[w-8] = merge(m_din[w-8], d, s);
        end
    endtask

    // One single-beat transfer: drive after a falling edge, sample the ack cycle at the next falling edge.
    task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd_v, output bit ak);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        @(negedge clk);
        ak = ack;
        rd_v = rdat_o;
        cyc = 0; stb = 0; we = 0; sel = 0; wdat = 0;
    endtask

    task automatic reg_wr(input int w, input logic [31:0] d, input logic [3:0] s, input string tag);
        wb_xfer(1, BASE + 32'(w * 4), d, s, got, acked);
        chk({tag, "_ack"}, 128'(acked), 128'(1));
        model_write(w, d, s);
    endtask

    task automatic reg_rd(input int w, input string tag);
        wb_xfer(0, BASE + 32'(w * 4), 32'h0, 4'hF, got, acked);
        chk({tag, "_ack"}, 128'(acked), 128'(1));
        chk({tag, "_dat"}, 128'(got), 128'(exp_read(w)));
    endtask

    task automatic core_done_pulse(input logic [127:0] v);
        @(negedge clk);
        done_i = 1; dout_i = v;
        @(negedge clk);
        done_i = 0; dout_i = '0;
        if (m_busy) begin
            for (int i = 0; i < 4; i++) m_dout[i] = v[32*i +: 32];
            m_done = 1;
            m_busy = 0;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", 128'(ack), 128'(0));
        chk("rst_start", 128'(start_o), 128'(0));
        chk("rst_irq", 128'(irq), 128'(0));
        chk("rst_key", key_o, 128'(0));
        chk("rst_din", din_o, 128'(0));
        rst = 0;

        // 1: status after reset, ack drops the following cycle
        reg_rd(1, "t1_status");
        chk("t1_irq", 128'(irq), 128'(0));
        @(negedge clk);
        chk("t1_ack_low", 128'(ack), 128'(0));

        // held read is acked every other cycle
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h4; sel = 4'hF;
        pat = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = ack;
        end
        cyc = 0; stb = 0;
        chk("held_ack_pattern", 128'(pat), 128'(4'b0101));

        // 2: byte-selected key write, miss address
        reg_wr(4, 32'h2B7E1516, 4'b0011, "t2_key0_wr");
        reg_rd(4, "t2_key0_rd");
        chk("t2_key0_val", 128'(got), 128'(32'h0000_1516));
        wb_xfer(1, BASE + 32'h100, 32'hDEAD_BEEF, 4'hF, got, acked);
        chk("t2_miss_ack", 128'(acked), 128'(0));
        chk("t2_miss_dat", 128'(got), 128'(0));

        // randomized idle-state accesses
        for (int it = 0; it < 60; it++) begin
            int w;
            bit wr_b, miss;
            logic [31:0] d, a;
            logic [3:0] s;
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
            wr_b = $urandom_range(0, 1) == 1;
            miss = $urandom_range(0, 7) == 0;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (w == 0) d[0] = 1'b0;
            a = BASE + 32'(w * 4);
            if (miss) a = a | (32'($urandom_range(1, 255)) << 8);
            wb_xfer(wr_b, a, d, s, got, acked);
            if (miss) begin
                chk("rnd_miss_ack", 128'(acked), 128'(0));
                chk("rnd_miss_dat", 128'(got), 128'(0));
            end else begin
                chk("rnd_ack", 128'(acked), 128'(1));
                if (wr_b) model_write(w, d, s);
                else chk("rnd_rdat", 128'(got), 128'(exp_read(w)));
            end
        end
        for (int w = 0; w < 16; w++) reg_rd(w, "rnd_sweep");
        chk("rnd_core_key", key_o, {m_key[3], m_key[2], m_key[1], m_key[0]});
        chk("rnd_core_din", din_o, {m_din[3], m_din[2], m_din[1], m_din[0]});

        // 3: full operation
        reg_wr(4, 32'h2B7E1516, 4'hF, "t3_k0");
        reg_wr(5, 32'h28AED2A6, 4'hF, "t3_k1");
        reg_wr(6, 32'hABF71588, 4'hF, "t3_k2");
        reg_wr(7, 32'h09CF4F3C, 4'hF, "t3_k3");
        reg_wr(8, 32'h3243F6A8, 4'hF, "t3_d0");
        reg_wr(9, 32'h885A308D, 4'hF, "t3_d1");
        reg_wr(10, 32'h313198A2, 4'hF, "t3_d2");
        reg_wr(11, 32'hE0370734, 4'hF, "t3_d3");
        chk("t3_core_key", key_o, 128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516);
        chk("t3_core_din", din_o, 128'hE0370734_313198A2_885A308D_3243F6A8);
        reg_wr(0, 32'h3, 4'hF, "t3_ctrl");
        chk("t3_start_hi", 128'(start_o), 128'(1));
        @(negedge clk);
        chk("t3_start_lo", 128'(start_o), 128'(0));
        reg_rd(1, "t3_busy");
        core_done_pulse(128'h3925841D_02DC09FB_DC118597_196A0B32);
        chk("t3_irq_lag", 128'(irq), 128'(0));
        @(negedge clk);
        chk("t3_irq", 128'(irq), 128'(1));
        reg_rd(12, "t3_dout0");
        chk("t3_dout0_val", 128'(got), 128'(32'h196A0B32));
        for (int w = 13; w < 16; w++) reg_rd(w, "t3_dout");
        reg_rd(1, "t3_status");

        // 4: writes while busy, done outside WAIT
        reg_wr(1, 32'h2, 4'h1, "t4_w1c");
        reg_rd(1, "t4_status_clr");
        chk("t4_irq_clr", 128'(irq), 128'(0));
        reg_wr(0, 32'h3, 4'hF, "t4_ctrl");
        reg_wr(8, 32'h1111_2222, 4'hF, "t4_din_busy");
        reg_wr(0, 32'h3, 4'hF, "t4_restart");
        chk("t4_no_start", 128'(start_o), 128'(0));
        @(negedge clk);
        chk("t4_no_start2", 128'(start_o), 128'(0));
        reg_rd(8, "t4_din0");
        blk = {$urandom, $urandom, $urandom, $urandom};
        core_done_pulse(blk);
        reg_rd(12, "t4_dout0");
        reg_rd(15, "t4_dout3");
        reg_wr(1, 32'h2, 4'h1, "t4_w1c2");
        core_done_pulse(~blk);
        reg_rd(1, "t4_stray_status");
        reg_rd(13, "t4_stray_dout1");

        // 5: timeout boundary, then W1C colliding with a fresh timeout
        reg_wr(0, 32'h3, 4'hF, "t5_start");
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            if (k == 256) chk("t5_irq_before", 128'(irq), 128'(0));
            if (k == 257) chk("t5_irq_after", 128'(irq), 128'(1));
        end
        m_busy = 0; m_to = 1;
        reg_rd(1, "t5_status_to");
        reg_wr(1, 32'h4, 4'h1, "t5_w1c");
        reg_rd(1, "t5_status_clr");
        reg_wr(1, 32'h0, 4'h1, "t5_w1c_none");
        reg_wr(0, 32'h3, 4'hF, "t5_start2");
        for (int k = 1; k <= 254; k++) @(negedge clk);
        wb_xfer(1, BASE + 32'h4, 32'h4, 4'h1, got, acked);
        chk("t5_race_ack", 128'(acked), 128'(1));
        m_busy = 0; m_to = 1;
        reg_rd(1, "t5_race_status");

        // 6: reset during WAIT and during an ack cycle
        reg_wr(1, 32'h6, 4'h1, "t6_clr");
        reg_wr(0, 32'h3, 4'hF, "t6_go");
        core_done_pulse(128'h1);
        reg_wr(0, 32'h3, 4'hF, "t6_go2");
        repeat (3) @(negedge clk);
        chk("t6_irq_pre", 128'(irq), 128'(1));
        rst = 1;
        #1;
        chk("t6_wait_start", 128'(start_o), 128'(0));
        chk("t6_wait_irq", 128'(irq), 128'(0));
        chk("t6_wait_ack", 128'(ack), 128'(0));
        @(negedge clk);
        rst = 0;
        model_reset();
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE; wdat = 32'h3; sel = 4'hF;
        @(posedge clk);
        #1;
        chk("t6_ack_pre", 128'(ack), 128'(1));
        chk("t6_start_pre", 128'(start_o), 128'(1));
        rst = 1;
        #1;
        chk("t6_ack_rst", 128'(ack), 128'(0));
        chk("t6_start_rst", 128'(start_o), 128'(0));
        chk("t6_irq_rst", 128'(irq), 128'(0));
        cyc = 0; stb = 0; we = 0; sel = 0; wdat = 0;
        @(negedge clk);
        rst = 0;
        reg_rd(1, "t6_status");
        reg_rd(4, "t6_key0");
        chk("t6_key_o", key_o, 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach the end in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_wb_regs.md
Name: aes_wb_regs

Overview:
- Wishbone classic slave register front-end between the user-project Wishbone port and the AES core datapath.
- Holds key, plaintext and result registers, and sequences a start/done handshake with the core.
- Reports status and raises an interrupt on completion or timeout.
- Sits directly downstream of the wrapper's wbs_* pins and upstream of the AES round engine.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the register window.
- ADDR_MASK, 32'hFFFF_FF00, address bits compared against BASE_ADDR for a hit.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before abort; width is clog2(TIMEOUT_CYCLES+1).

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- core_key_o  out  128  key to core; word0 = bits [31:0].
- core_din_o  out  128  plaintext to core.
- core_start_o  out  1  one-cycle start pulse.
- core_done_i  in  1  one-cycle completion pulse from core.
- core_dout_i  in  128  result, valid when core_done_i is high.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset: all outputs 0, all registers 0, FSM in IDLE.
- Hit condition: wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR) & !wbs_ack_o.
- Ack timing: wbs_ack_o is registered, high exactly one cycle after a hit and low the next cycle. A held request is acked once per 2 cycles.
- No hit: no ack (another slave owns the address); wbs_dat_o stays 0.
- Read data: wbs_dat_o is registered together with ack; it is 0 whenever ack is low.
- Register map (word offset = wbs_adr_i[7:2]):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (R/W).
  - 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 TIMEOUT (sticky, W1C).
  - 0x10-0x1C KEY0..3 (R/W).
  - 0x20-0x2C DIN0..3 (R/W).
  - 0x30-0x3C DOUT0..3 (RO; writes ignored).
  - Unmapped offsets: reads 0, writes ignored, still acked.
- Byte selects: writes honour wbs_sel_i per byte. For CTRL, START/IRQ_EN act only when sel[0] is set. For STATUS W1C, sel[0] is required.
- Writes to KEY/DIN while BUSY are acked but ignored.
- FSM states:
  - IDLE: a START write goes to START.
  - START: core_start_o=1 for exactly this cycle; next state is WAIT. The write's ack and the START state coincide.
  - WAIT: core_done_i captures core_dout_i into DOUT, sets DONE, returns to IDLE. If the counter reaches TIMEOUT_CYCLES with no done: set TIMEOUT, return to IDLE, DOUT unchanged.
- BUSY = (state != IDLE).
- START write while BUSY is ignored. core_done_i outside WAIT is ignored (no DONE, no capture).
- Counter: clears on entering WAIT, increments each WAIT cycle, saturates.
- Simultaneous W1C and hardware set of DONE or TIMEOUT in the same cycle: set wins.
- irq_o = IRQ_EN & (DONE | TIMEOUT), registered.
- Reset asserted mid-operation: immediate return to reset values. A pending ack is dropped and core_start_o is forced low.

Decomposition:
- Package aes_wb_pkg:
  - register offset localparams;
  - CTRL/STATUS bit index constants;
  - FSM state enum {IDLE, START, WAIT};
  - the 128-bit block width constant.
- One natural sub-module: aes_wb_ack_gen (hit decode plus registered single-cycle ack). Register file and FSM stay in the top.

Test Plan:
1. Reset, then read STATUS at BASE_ADDR+0x04 -> ack 1 cycle after strobe, data 32'h0, irq_o=0.
2. Write KEY0=32'h2B7E1516 with sel=4'b0011, then read KEY0 -> 32'h00001516. Write to BASE_ADDR+0x100 -> no ack.
3. Load KEY/DIN, write CTRL=32'h3 -> core_start_o high for exactly 1 cycle, BUSY=1. Core pulses done with dout=128'h3925841D_02DC09FB_DC118597_196A0B32 -> DOUT0 reads 32'h196A0B32, DONE=1, irq_o=1 next cycle.
4. Start, then write DIN0 and CTRL.START while BUSY -> DIN0 unchanged, no second core_start_o. Core done with no START write -> no capture.
5. Start with core silent -> after 255 WAIT cycles TIMEOUT=1, BUSY=0. W1C STATUS=32'h4 in the same cycle as a new timeout -> TIMEOUT stays 1.
6. Assert wb_rst_i during WAIT and during an ack cycle -> wbs_ack_o, core_start_o, irq_o go 0 immediately. STATUS reads 0 after release.
